// File: rtl/cov_frame_ctrl_if.sv
// cov_frame_ctrl_if: sample, accumulator, result and record buses around cov_frame_ctrl
interface cov_frame_ctrl_if #(
    parameter int DW = 128,
    parameter int OW = 64
);
    logic          s_valid;
    logic          s_sof;
    logic [DW-1:0] s_data;
    logic          acc_valid;
    logic          acc_first;
    logic [DW-1:0] acc_data;
    logic          cov_vd;
    logic [OW-1:0] cov_data;
    logic          m_valid;
    logic [OW-1:0] m_data;
    logic          m_last;
    modport master (
        output s_valid, s_sof, s_data, cov_vd, cov_data,
        input  acc_valid, acc_first, acc_data, m_valid, m_data, m_last
    );
    modport slave (
        input  s_valid, s_sof, s_data, cov_vd, cov_data,
        output acc_valid, acc_first, acc_data, m_valid, m_data, m_last
    );
endinterface

// File: rtl/cov_frame_ctrl.sv
// cov_frame_ctrl: frame sequencer feeding cov_matrix and emitting one result+timestamp record per frame
module cov_frame_ctrl #(
    parameter int FRAME_SIZE         = 2048,
    parameter int DESIRED_FRAME_SIZE = 2000,
    parameter int SKIP_FRAME_SAMPLES = 48,
    parameter int INPUT_ELEMENTS     = 4,
    parameter int INPUT_DATA_WIDTH   = 16,
    parameter int OUTPUT_DATA_WIDTH  = 64,
    parameter int RESULT_WORDS       = 20,
    parameter int DRAIN_TIMEOUT      = 4096,
    parameter int TS_WIDTH           = 48
) (
    input  logic                   clk_x4,
    input  logic                   rst_n,
    input  logic                   cfg_enable,
    input  logic                   err_clr,
    cov_frame_ctrl_if.slave        bus,
    output logic                   busy,
    output logic                   err_short,
    output logic                   err_timeout,
    output logic                   err_overrun,
    output logic                   err_spurious,
    output logic [15:0]            drop_cnt
);
    localparam int SC_W = $clog2(FRAME_SIZE + 1);
    localparam int RC_W = $clog2(RESULT_WORDS + 1);
    localparam int TC_W = $clog2(DRAIN_TIMEOUT + 1);

    if (SKIP_FRAME_SAMPLES != FRAME_SIZE - DESIRED_FRAME_SIZE) begin : g_skip_chk
        $error("SKIP_FRAME_SAMPLES must equal FRAME_SIZE-DESIRED_FRAME_SIZE");
    end

    typedef enum logic [2:0] {IDLE, ACCUM, SKIP, DRAIN, STAMP} state_t;

    state_t                                      state, state_n;
    logic [SC_W-1:0]                             scnt, scnt_n;
    logic [RC_W-1:0]                             res_cnt, res_n;
    logic [TC_W-1:0]                             tcnt, tcnt_n;
    logic [TS_WIDTH-1:0]                         ts, ts_sof;
    logic [15:0]                                 frame_idx;
    logic [INPUT_ELEMENTS*2*INPUT_DATA_WIDTH-1:0] s_data_w;
    logic sof, start, collect, take, e_short, e_over, e_spur, e_tmo, drop_ev;

    assign s_data_w = bus.s_data;
    assign busy     = state != IDLE;

    always_comb begin
        sof     = bus.s_valid & bus.s_sof;
        e_short = sof & (state == ACCUM || state == SKIP);
        e_over  = sof & (state == DRAIN || state == STAMP);
        // a sof inside an open frame restarts it even when new frames are disabled
        start   = e_short | (sof & cfg_enable & (state == IDLE));
        collect = (state == SKIP || state == DRAIN) && res_cnt < RC_W'(RESULT_WORDS);
        take    = bus.cov_vd & collect;
        e_spur  = bus.cov_vd & ~collect;
        e_tmo   = 1'b0;
        state_n = state;
        scnt_n  = scnt + SC_W'(bus.s_valid);
        res_n   = res_cnt + RC_W'(take);
        tcnt_n  = tcnt + 1'b1;
        if (start) begin
            state_n = ACCUM;
            scnt_n  = SC_W'(1);
            res_n   = '0;
        end else begin
            case (state)
                ACCUM: state_n = bus.s_valid && scnt_n == SC_W'(DESIRED_FRAME_SIZE) ? SKIP : ACCUM;
                SKIP: begin
                    if (bus.s_valid && scnt_n == SC_W'(FRAME_SIZE)) begin
                        state_n = res_n == RC_W'(RESULT_WORDS) ? STAMP : DRAIN;
                        tcnt_n  = '0;
                    end
                end
                DRAIN: begin
                    if (res_n == RC_W'(RESULT_WORDS)) begin
                        state_n = STAMP;
                    end else if (tcnt == TC_W'(DRAIN_TIMEOUT - 1)) begin
                        state_n = IDLE;
                        e_tmo   = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        drop_ev = e_short | e_over | e_tmo;
    end

    always_ff @(posedge clk_x4 or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            scnt          <= '0;
            res_cnt       <= '0;
            tcnt          <= '0;
            ts            <= '0;
            ts_sof        <= '0;
            frame_idx     <= '0;
            bus.acc_valid <= 1'b0;
            bus.acc_first <= 1'b0;
            bus.acc_data  <= '0;
            bus.m_valid   <= 1'b0;
            bus.m_last    <= 1'b0;
            bus.m_data    <= '0;
            err_short     <= 1'b0;
            err_timeout   <= 1'b0;
            err_overrun   <= 1'b0;
            err_spurious  <= 1'b0;
            drop_cnt      <= '0;
        end else begin
            state         <= state_n;
            scnt          <= scnt_n;
            res_cnt       <= res_n;
            tcnt          <= tcnt_n;
            ts            <= ts + 1'b1;
            ts_sof        <= start ? ts : ts_sof;
            frame_idx     <= frame_idx + 16'(state == STAMP);
            bus.acc_valid <= start | (state == ACCUM & bus.s_valid);
            bus.acc_first <= start;
            bus.acc_data  <= s_data_w;
            bus.m_valid   <= take | (state == STAMP);
            bus.m_last    <= state == STAMP;
            bus.m_data    <= state == STAMP ? OUTPUT_DATA_WIDTH'({frame_idx, ts_sof}) : bus.cov_data;
            // a new error in the same cycle as err_clr leaves its flag set
            err_short     <= (err_short & ~err_clr) | e_short;
            err_timeout   <= (err_timeout & ~err_clr) | e_tmo;
            err_overrun   <= (err_overrun & ~err_clr) | e_over;
            err_spurious  <= (err_spurious & ~err_clr) | e_spur;
            drop_cnt      <= (err_clr ? 16'd0 : drop_cnt) + 16'(drop_ev & (err_clr | drop_cnt != 16'hFFFF));
        end
    end
endmodule

// File: tb/tb_cov_frame_ctrl.sv
// tb_cov_frame_ctrl: randomized directed steps for cov_frame_ctrl checked against a frame-level model
module tb_cov_frame_ctrl;
    localparam int FS = 2048, DS = 2000, RWN = 20;

    logic        clk_x4 = 1'b0, rst_n = 1'b0, cfg_enable = 1'b0, err_clr = 1'b0;
    logic        busy, err_short, err_timeout, err_overrun, err_spurious;
    logic [15:0] drop_cnt;
    int          checks = 0, failures = 0;
    int          acc_n = 0, first_n = 0, m_n = 0, last_n = 0;
    int          a0, f0, m0, l0;
    longint      cyc = 0;
    logic [15:0] fidx = 16'd0;
    logic [128:0] acc_q[$];
    logic [64:0]  m_q[$];

    cov_frame_ctrl_if #(.DW(128), .OW(64)) bus ();

    cov_frame_ctrl dut (
        .clk_x4(clk_x4), .rst_n(rst_n), .cfg_enable(cfg_enable), .err_clr(err_clr), .bus(bus),
        .busy(busy), .err_short(err_short), .err_timeout(err_timeout), .err_overrun(err_overrun),
        .err_spurious(err_spurious), .drop_cnt(drop_cnt)
    );

    always #5 clk_x4 = ~clk_x4;

    always @(posedge clk_x4 or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic mon();
        logic [128:0] a;
        logic [64:0]  w;
        chk("acc_valid", 128'(bus.acc_valid), 128'(acc_q.size() != 0));
        if (bus.acc_valid) begin
            acc_n++;
            if (bus.acc_first) first_n++;
            if (acc_q.size() != 0) begin
                a = acc_q.pop_front();
                chk("acc_first", 128'(bus.acc_first), 128'(a[128]));
                chk("acc_data", bus.acc_data, a[127:0]);
            end
        end
        if (bus.m_valid) begin
            m_n++;
            if (bus.m_last) last_n++;
            checks++;
            assert (m_q.size() != 0) else begin
                failures++;
                $error("FAIL m_unexpected observed=%0h expected=no_word", bus.m_data);
            end
            if (m_q.size() != 0) begin
                w = m_q.pop_front();
                chk("m_last", 128'(bus.m_last), 128'(w[64]));
                chk("m_data", 128'(bus.m_data), 128'(w[63:0]));
            end
        end else begin
            chk("m_last_idle", 128'(bus.m_last), 128'(0));
        end
    endtask

    task automatic step(input logic v, input logic so, input logic cv, input logic ec);
        @(negedge clk_x4);
        mon();
        bus.s_valid  = v;
        bus.s_sof    = so;
        bus.s_data   = {$urandom, $urandom, $urandom, $urandom};
        bus.cov_vd   = cv;
        bus.cov_data = {$urandom, $urandom};
        err_clr      = ec;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // n samples at duty% density; nres result words start delay cycles after res_at samples
    task automatic frame(input int n, input int duty, input int nres, input int res_at, input int delay, input bit ovr);
        int     i = 0, r = 0, pc = 0, taken = 0;
        bit     v, so, cv, ov, stamped = 0;
        longint ts0 = 0;
        while (i < n || r < nres) begin
            v  = i < n && (i == 0 || duty >= 100 || $urandom_range(0, 99) < duty);
            so = v && i == 0;
            cv = r < nres && i >= res_at && pc >= delay;
            ov = ovr && i >= n && pc == 50;
            step(v | ov, so | ov, cv, 1'b0);
            if (so) ts0 = cyc;
            if (v && i < DS) acc_q.push_back({so, bus.s_data});
            if (cv && i >= DS && taken < RWN) begin
                m_q.push_back({1'b0, bus.cov_data});
                taken++;
            end
            if (v) i++;
            if (cv) r++;
            if (i >= res_at) pc++;
            if (!stamped && taken == RWN && i == FS) begin
                m_q.push_back({1'b1, fidx, ts0[47:0]});
                fidx++;
                stamped = 1;
            end
        end
    endtask

    task automatic snap();
        a0 = acc_n; f0 = first_n; m0 = m_n; l0 = last_n;
    endtask

    task automatic rec_chk(input string tag, input int acc, input int firsts, input int words, input int lasts);
        chk({tag, "_acc_cnt"}, 128'(acc_n - a0), 128'(acc));
        chk({tag, "_first_cnt"}, 128'(first_n - f0), 128'(firsts));
        chk({tag, "_m_cnt"}, 128'(m_n - m0), 128'(words));
        chk({tag, "_last_cnt"}, 128'(last_n - l0), 128'(lasts));
        chk({tag, "_m_q_empty"}, 128'(m_q.size()), 128'(0));
    endtask

    initial begin
        bus.s_valid = 1'b0; bus.s_sof = 1'b0; bus.s_data = '0; bus.cov_vd = 1'b0; bus.cov_data = '0;
        idle(3);
        chk("rst_acc_valid", 128'(bus.acc_valid), 128'(0));
        chk("rst_acc_data", bus.acc_data, 128'(0));
        chk("rst_m_data", 128'(bus.m_data), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_errs", 128'({err_short, err_timeout, err_overrun, err_spurious}), 128'(0));
        chk("rst_drop", 128'(drop_cnt), 128'(0));
        rst_n = 1'b1;
        cfg_enable = 1'b1;
        idle(2);

        snap();
        frame(FS, 100, RWN, 2010, 0, 0);
        idle(8);
        rec_chk("nominal", DS, 1, RWN + 1, 1);
        chk("nominal_busy", 128'(busy), 128'(0));
        chk("nominal_errs", 128'({err_short, err_timeout, err_overrun, err_spurious}), 128'(0));

        snap();
        frame(FS, 50, RWN, FS, 100, 0);
        idle(8);
        rec_chk("gapped", DS, 1, RWN + 1, 1);

        snap();
        frame(1500, 100, 0, 0, 0, 0);
        frame(FS, 100, RWN, 2010, 0, 0);
        idle(8);
        rec_chk("short", 1500 + DS, 2, RWN + 1, 1);
        chk("short_err", 128'(err_short), 128'(1));
        chk("short_drop", 128'(drop_cnt), 128'(1));

        snap();
        frame(FS, 100, RWN - 1, 2010, 0, 0);
        idle(4090);
        chk("tmo_early_err", 128'(err_timeout), 128'(0));
        chk("tmo_early_busy", 128'(busy), 128'(1));
        idle(10);
        chk("tmo_err", 128'(err_timeout), 128'(1));
        chk("tmo_busy", 128'(busy), 128'(0));
        chk("tmo_drop", 128'(drop_cnt), 128'(2));
        rec_chk("tmo", DS, 1, RWN - 1, 0);

        snap();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        chk("spur_idle_err", 128'(err_spurious), 128'(1));
        chk("spur_idle_m", 128'(m_n - m0), 128'(0));
        chk("sticky_short", 128'(err_short), 128'(1));
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        chk("clr_errs", 128'({err_short, err_timeout, err_overrun, err_spurious}), 128'(0));
        chk("clr_drop", 128'(drop_cnt), 128'(0));

        snap();
        frame(FS, 100, RWN + 1, FS, 100, 1);
        idle(8);
        rec_chk("ovr", DS, 1, RWN + 1, 1);
        chk("ovr_err", 128'(err_overrun), 128'(1));
        chk("ovr_spur", 128'(err_spurious), 128'(1));
        chk("ovr_drop", 128'(drop_cnt), 128'(1));
        step(1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);
        chk("clr_race_spur", 128'(err_spurious), 128'(1));
        chk("clr_race_ovr", 128'(err_overrun), 128'(0));
        chk("clr_race_drop", 128'(drop_cnt), 128'(0));
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        snap();
        cfg_enable = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        chk("dis_busy", 128'(busy), 128'(0));
        chk("dis_acc", 128'(acc_n - a0), 128'(0));
        cfg_enable = 1'b1;

        frame(1000, 100, 0, 0, 0, 0);
        @(posedge clk_x4);
        #2;
        chk("pre_rst_acc", 128'(bus.acc_valid), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("async_rst_acc", 128'({bus.acc_valid, bus.acc_first}), 128'(0));
        chk("async_rst_busy", 128'(busy), 128'(0));
        acc_q.delete();
        m_q.delete();
        fidx = 16'd0;
        idle(3);
        rst_n = 1'b1;
        snap();
        frame(FS, 100, RWN, 2010, 0, 0);
        idle(8);
        rec_chk("post_rst", DS, 1, RWN + 1, 1);
        chk("acc_q_empty", 128'(acc_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cov_frame_ctrl.md
Name: cov_frame_ctrl

Overview:
Frame sequencer in front of cov_matrix. It takes the 4-channel complex sample stream and marks frame boundaries. It gates data_in_valid to the first DESIRED_FRAME_SIZE samples of each FRAME_SIZE frame, then collects the RESULT_WORDS result words from cov_matrix and appends one timestamp word. This produces the 21-word per-frame record that the monitor/scoreboard consume.

Parameters:
FRAME_SIZE, 2048, samples per input frame
DESIRED_FRAME_SIZE, 2000, leading samples forwarded to cov_matrix
SKIP_FRAME_SAMPLES, 48, trailing samples dropped; must equal FRAME_SIZE-DESIRED_FRAME_SIZE (elaboration check)
INPUT_ELEMENTS, 4, channels
INPUT_DATA_WIDTH, 16, width of each I or Q component
OUTPUT_DATA_WIDTH, 64, result word width
RESULT_WORDS, 20, cov_matrix words per frame (10 complex, real then imag)
DRAIN_TIMEOUT, 4096, clk_x4 cycles allowed in DRAIN
TS_WIDTH, 48, free-running timestamp width

Ports:
clk_x4  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cfg_enable  in  1  allow new frames to start
err_clr  in  1  clears sticky errors and drop_cnt
s_valid  in  1  input sample valid
s_sof  in  1  first sample of frame; qualified by s_valid
s_data  in  INPUT_ELEMENTS*2*INPUT_DATA_WIDTH  packed {ch4_q,ch4_i,...,ch1_q,ch1_i}
acc_valid  out  1  to cov_matrix data_in_valid
acc_first  out  1  first accumulated sample of frame (restart accumulation)
acc_data  out  INPUT_ELEMENTS*2*INPUT_DATA_WIDTH  registered s_data
cov_vd  in  1  cov_matrix vd_out
cov_data  in  OUTPUT_DATA_WIDTH  cov_matrix result word
m_valid  out  1  record word valid
m_data  out  OUTPUT_DATA_WIDTH  record word
m_last  out  1  timestamp word (word 20)
busy  out  1  state != IDLE
err_short, err_timeout, err_overrun, err_spurious  out  1 each  sticky error flags
drop_cnt  out  16  frames dropped, saturating

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0; timestamp counter ts 0. ts increments every cycle and wraps.
- States: IDLE, ACCUM, SKIP, DRAIN, STAMP.
- Sample counter scnt counts accepted samples, where accepted means s_valid=1. s_sof with s_valid=0 is ignored.
- IDLE:
  - s_valid&s_sof&cfg_enable -> ACCUM, scnt=1; latch ts_sof=ts, res_cnt=0.
  - Sample forwarded as first sample.
  - Samples without sof, or any sample while cfg_enable=0, are ignored.
- ACCUM:
  - Each accepted sample is forwarded.
  - Sample number DESIRED_FRAME_SIZE -> SKIP.
- Forwarding timing:
  - acc_valid, acc_first and acc_data are registered, 1-cycle latency from the input cycle.
  - acc_first=1 only alongside the sof sample.
  - acc_valid=0 for skipped samples.
- SKIP:
  - Accepted samples are counted, not forwarded.
  - When scnt reaches FRAME_SIZE: res_cnt==RESULT_WORDS -> STAMP, else -> DRAIN with the timeout counter cleared.
- Short frame:
  - s_valid&s_sof in ACCUM or SKIP sets err_short and increments drop_cnt; the partial frame produces no record.
  - It restarts as in IDLE in the same cycle (acc_first=1 next cycle), regardless of cfg_enable.
- Result collection (SKIP, DRAIN):
  - Each cov_vd while res_cnt<RESULT_WORDS -> m_valid=1, m_data=cov_data next cycle, res_cnt++.
  - cov_vd in any other state, or beyond RESULT_WORDS, sets err_spurious and the word is dropped.
- DRAIN:
  - res_cnt reaching RESULT_WORDS -> STAMP on the following cycle.
  - Timeout counter reaching DRAIN_TIMEOUT -> err_timeout, drop_cnt++, go to IDLE with no stamp word.
  - Any s_valid&s_sof in DRAIN or STAMP -> err_overrun, drop_cnt++, frame ignored (not started).
- STAMP (one cycle):
  - Next cycle m_valid=1, m_last=1, m_data={frame_idx[15:0], ts_sof[47:0]} (zero-extended/truncated to OUTPUT_DATA_WIDTH).
  - frame_idx++ (wraps); -> IDLE.
- A record is exactly RESULT_WORDS+1 words; m_last only on the final word.
- Simultaneous events:
  - If the cov_vd that fills res_cnt arrives in the same cycle as the SKIP exit, go -> STAMP.
  - err_clr in the same cycle as a new error: the error wins (flag set).
- drop_cnt saturates at 0xFFFF.
- cfg_enable deasserted mid-frame does not abort the frame; it only blocks the next IDLE start.
- rst_n asserted mid-frame: immediate return to reset values. No partial record completes, and acc_valid drops asynchronously.

Test Plan:
- Nominal: enable=1, 2048 consecutive valid samples with sof on #0; cov model returns 20 words during SKIP -> 2000 acc_valid pulses, acc_first on the first only; 21 m_valid words, m_last on word 21 with frame_idx=0 and ts_sof equal to the sof cycle count.
- Gapped input plus late results: s_valid 50% duty; results arrive 100 cycles after the frame ends -> DRAIN then STAMP; still 2000 forwarded samples and 21 words; second frame stamp has frame_idx=1.
- Short frame: new sof after sample 1500 -> err_short=1, drop_cnt=1, no m_last for the aborted frame; the new frame completes normally.
- Timeout: only 19 cov_vd words returned -> after 4096 DRAIN cycles err_timeout=1, drop_cnt++, no stamp word, state IDLE.
- Overrun/spurious: sof during DRAIN -> err_overrun, frame ignored. A 21st cov_vd, or cov_vd in IDLE -> err_spurious, no m_valid. err_clr clears all flags and drop_cnt.
- Reset mid-ACCUM: rst_n low at sample 1000 -> all outputs 0 asynchronously; after release a fresh frame produces a full record with frame_idx=0.
